id_ex_reg: RTL and testbench

ID_EX_REG -- requirements
Module: id_ex_reg

---
 rtl/id_ex_reg.sv | 81 ++++++++
 tb/tb_id_ex_reg.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with write-back bypass into the captured operands
// and a combinational load-use hazard detector looking at the EX slot.
module id_ex_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        id_valid,
  input  logic [31:0] id_pc,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic [4:0]  id_rd_addr,
  input  logic [31:0] id_rs1_data,
  input  logic [31:0] id_rs2_data,
  input  logic [31:0] id_imm,
  input  logic [3:0]  id_alu_sel,
  input  logic        id_b_sel,
  input  logic [3:0]  id_ctrl,
  input  logic        wb_wen,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic [4:0]  ex_rd_addr,
  output logic [31:0] ex_op_a,
  output logic [31:0] ex_op_b,
  output logic [31:0] ex_rs2_data,
  output logic [4:0]  ex_shamt,
  output logic [3:0]  ex_alu_sel,
  output logic [3:0]  ex_ctrl,
  output logic        load_use
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;

  logic            w_rs1_hit;
  logic            w_rs2_hit;
  logic [XLEN-1:0] w_rs1_val;
  logic [XLEN-1:0] w_rs2_val;
  logic            w_bubble;

  // Register-file write in the same cycle is not yet visible on the read ports.
  always_comb begin
    w_rs1_hit = wb_wen && (wb_rd != RW'(0)) && (wb_rd == id_rs1_addr);
    w_rs2_hit = wb_wen && (wb_rd != RW'(0)) && (wb_rd == id_rs2_addr);
    w_rs1_val = w_rs1_hit ? wb_data : id_rs1_data;
    w_rs2_val = w_rs2_hit ? wb_data : id_rs2_data;
    w_bubble  = rst || flush || (!stall && !id_valid);
  end

  // Priority: reset/flush clear, stall holds, otherwise capture ID.
  always_ff @(posedge clk) begin
    if (w_bubble) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_rd_addr  <= '0;
      ex_op_a     <= '0;
      ex_op_b     <= '0;
      ex_rs2_data <= '0;
      ex_alu_sel  <= '0;
      ex_ctrl     <= '0;
    end else if (!stall) begin
      ex_valid    <= 1'b1;
      ex_pc       <= id_pc;
      ex_rd_addr  <= id_rd_addr;
      ex_op_a     <= w_rs1_val;
      ex_op_b     <= id_b_sel ? id_imm : w_rs2_val;
      ex_rs2_data <= w_rs2_val;
      ex_alu_sel  <= id_alu_sel;
      ex_ctrl     <= id_ctrl;
    end
  end

  assign ex_shamt = ex_op_b[RW-1:0];

  // rs2 match counts even for immediate-form instructions (conservative).
  assign load_use = ex_valid && ex_ctrl[1] && (ex_rd_addr != RW'(0)) && id_valid &&
                    ((ex_rd_addr == id_rs1_addr) || (ex_rd_addr == id_rs2_addr));

endmodule

// File: tb/tb_id_ex_reg.sv
// Scoreboard bench for id_ex_reg: expected EX state is queued when a cycle's
// inputs are applied and compared after the following rising edge.
module tb_id_ex_reg;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] rs2;
    logic [3:0]  alu;
    logic [3:0]  ctrl;
  } ex_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1, stall = 1'b0, flush = 1'b0, id_valid = 1'b0;
  logic [31:0] id_pc = '0, id_rs1_data = '0, id_rs2_data = '0, id_imm = '0, wb_data = '0;
  logic [4:0]  id_rs1_addr = '0, id_rs2_addr = '0, id_rd_addr = '0, wb_rd = '0;
  logic [3:0]  id_alu_sel = '0, id_ctrl = '0;
  logic        id_b_sel = 1'b0, wb_wen = 1'b0;

  logic        ex_valid, load_use;
  logic [31:0] ex_pc, ex_op_a, ex_op_b, ex_rs2_data;
  logic [4:0]  ex_rd_addr, ex_shamt;
  logic [3:0]  ex_alu_sel, ex_ctrl;

  int   checks = 0;
  int   failures = 0;
  ex_t  model = '0;
  ex_t  sb_q[$];

  id_ex_reg dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_pc(id_pc), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rd_addr(id_rd_addr), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_alu_sel(id_alu_sel), .id_b_sel(id_b_sel), .id_ctrl(id_ctrl),
    .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd_addr(ex_rd_addr), .ex_op_a(ex_op_a),
    .ex_op_b(ex_op_b), .ex_rs2_data(ex_rs2_data), .ex_shamt(ex_shamt),
    .ex_alu_sel(ex_alu_sel), .ex_ctrl(ex_ctrl), .load_use(load_use)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic ex_t next_ex(input ex_t cur);
    ex_t n;
    logic [31:0] a, b;
    if (rst || flush) return '0;
    if (stall) return cur;
    if (!id_valid) return '0;
    a = (wb_wen && wb_rd != 5'd0 && wb_rd == id_rs1_addr) ? wb_data : id_rs1_data;
    b = (wb_wen && wb_rd != 5'd0 && wb_rd == id_rs2_addr) ? wb_data : id_rs2_data;
    n.valid = 1'b1;
    n.pc    = id_pc;
    n.rd    = id_rd_addr;
    n.op_a  = a;
    n.op_b  = id_b_sel ? id_imm : b;
    n.rs2   = b;
    n.alu   = id_alu_sel;
    n.ctrl  = id_ctrl;
    return n;
  endfunction

  function automatic logic exp_lu(input ex_t m);
    return m.valid && m.ctrl[1] && m.rd != 5'd0 && id_valid &&
           (m.rd == id_rs1_addr || m.rd == id_rs2_addr);
  endfunction

  // Called at posedge+1 after inputs are set: check hazard, push, clock, pop/compare.
  task automatic cycle(input string tag);
    ex_t e;
    #1;
    check_eq({tag, ".lu_pre"}, 32'(load_use), 32'(exp_lu(model)));
    sb_q.push_back(next_ex(model));
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    model = e;
    check_eq({tag, ".valid"}, 32'(ex_valid), 32'(e.valid));
    check_eq({tag, ".pc"},    ex_pc, e.pc);
    check_eq({tag, ".rd"},    32'(ex_rd_addr), 32'(e.rd));
    check_eq({tag, ".op_a"},  ex_op_a, e.op_a);
    check_eq({tag, ".op_b"},  ex_op_b, e.op_b);
    check_eq({tag, ".rs2"},   ex_rs2_data, e.rs2);
    check_eq({tag, ".shamt"}, 32'(ex_shamt), 32'(e.op_b[4:0]));
    check_eq({tag, ".alu"},   32'(ex_alu_sel), 32'(e.alu));
    check_eq({tag, ".ctrl"},  32'(ex_ctrl), 32'(e.ctrl));
    check_eq({tag, ".lu"},    32'(load_use), 32'(exp_lu(e)));
  endtask

  task automatic set_id(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] imm, input logic [3:0] alu, input logic bsel,
                        input logic [3:0] ctrl);
    id_valid = 1'b1; id_pc = pc; id_rs1_addr = rs1; id_rs2_addr = rs2; id_rd_addr = rd;
    id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_alu_sel = alu;
    id_b_sel = bsel; id_ctrl = ctrl;
  endtask

  initial begin
    // First edge establishes a known state; checks begin with a second reset cycle.
    @(posedge clk); #1;
    cycle("reset");
    rst = 1'b0;

    // Arithmetic right shift with immediate operand
    set_id(32'h100, 5'd1, 5'd2, 5'd3, 32'h8000_0000, 32'h55, 32'd3, 4'd7, 1'b1, 4'b0001);
    cycle("sra_imm");
    check_eq("sra_direct.op_a", ex_op_a, 32'h8000_0000);
    check_eq("sra_direct.shamt", 32'(ex_shamt), 32'd3);

    // Write-back bypass into rs1, then suppressed for x0
    set_id(32'h104, 5'd5, 5'd6, 5'd8, 32'h0, 32'h77, 32'h0, 4'd0, 1'b0, 4'b0001);
    wb_wen = 1'b1; wb_rd = 5'd5; wb_data = 32'h1234;
    cycle("bypass_rs1");
    check_eq("bypass_direct.op_a", ex_op_a, 32'h1234);
    wb_rd = 5'd0;
    cycle("bypass_x0");
    check_eq("bypass_x0_direct.op_a", ex_op_a, 32'h0);
    wb_rd = 5'd6; wb_data = 32'hCAFE_0006;
    cycle("bypass_rs2");

    // Stall holds A for three cycles regardless of new ID data and WB
    wb_wen = 1'b0;
    set_id(32'hA00, 5'd10, 5'd11, 5'd12, 32'hAAAA, 32'hBBBB, 32'h0, 4'd2, 1'b0, 4'b0101);
    cycle("load_a");
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_id(32'hB00 + 32'(i), 5'd13, 5'd14, 5'd15, 32'h1111 * 32'(i + 1), 32'h2, 32'h9,
             4'd6, 1'b1, 4'b1000);
      wb_wen = 1'b1; wb_rd = 5'd13; wb_data = 32'hDEAD;
      cycle("stall_hold");
      check_eq("stall_direct.pc", ex_pc, 32'hA00);
    end
    stall = 1'b0;
    cycle("stall_release");

    // Flush and stall together give a bubble
    wb_wen = 1'b0;
    stall = 1'b1; flush = 1'b1;
    cycle("flush_stall");
    check_eq("flush_direct.ctrl", 32'(ex_ctrl), 32'h0);
    stall = 1'b0; flush = 1'b0;

    // Load-use hazard on rs2, then with rd=x0
    set_id(32'hC00, 5'd1, 5'd2, 5'd7, 32'h5, 32'h6, 32'h0, 4'd0, 1'b1, 4'b0011);
    cycle("load_rd7");
    set_id(32'hC04, 5'd9, 5'd7, 5'd4, 32'h1, 32'h2, 32'h0, 4'd0, 1'b0, 4'b0001);
    stall = 1'b1;
    #1;
    check_eq("load_use_rs2", 32'(load_use), 32'd1);
    stall = 1'b0;
    set_id(32'hC08, 5'd1, 5'd2, 5'd0, 32'h5, 32'h6, 32'h0, 4'd0, 1'b1, 4'b0011);
    cycle("load_rd0");
    set_id(32'hC0C, 5'd0, 5'd0, 5'd4, 32'h1, 32'h2, 32'h0, 4'd0, 1'b0, 4'b0001);
    #1;
    check_eq("load_use_rd0", 32'(load_use), 32'd0);

    // Invalid ID instruction loads a bubble
    id_valid = 1'b0;
    cycle("id_invalid");

    // Reset during stall, then a normal load
    set_id(32'hD00, 5'd3, 5'd4, 5'd5, 32'h33, 32'h44, 32'h0, 4'd1, 1'b0, 4'b0011);
    cycle("pre_rst");
    stall = 1'b1; rst = 1'b1;
    cycle("rst_stall");
    check_eq("rst_stall_direct.valid", 32'(ex_valid), 32'd0);
    stall = 1'b0; rst = 1'b0;
    cycle("post_rst_load");

    // Randomised mix of controls, bypass and hazards
    for (int i = 0; i < 60; i++) begin
      set_id($urandom, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
             4'($urandom), 1'($urandom), 4'($urandom));
      id_valid = ($urandom_range(0, 4) != 0);
      stall    = ($urandom_range(0, 3) == 0);
      flush    = ($urandom_range(0, 7) == 0);
      rst      = ($urandom_range(0, 19) == 0);
      wb_wen   = 1'($urandom);
      wb_rd    = 5'($urandom_range(0, 7));
      wb_data  = $urandom;
      cycle("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
